// File: rtl/dpll_scan_master.sv
// Host-side serial driver for the DPLL configuration scan chain.
// Define SCAN_VERIFY_EN to flag readbacks that differ from the previously written word.
module dpll_scan_master #(
   parameter int CHAIN_LEN = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [CHAIN_LEN-1:0] i_wdata,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [CHAIN_LEN-1:0] o_rdata,
   output logic                 o_verify_err,
   output logic                 o_scan_en,
   output logic                 o_scan_out,
   input  logic                 i_scan_in
);

   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CHAIN_LEN-1:0] shreg_q, shreg_d;
   logic [CHAIN_LEN-1:0] rdata_q, rdata_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (i_start) state_d = S_SHIFT;
         S_SHIFT: if (cnt_q == LAST) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy     = 1'b0;
      o_done     = 1'b0;
      o_scan_en  = 1'b0;
      o_scan_out = 1'b0;
      unique case (state_q)
         S_SHIFT: begin
            o_busy     = 1'b1;
            o_scan_en  = 1'b1;
            o_scan_out = shreg_q[0];
         end
         S_DONE: begin
            o_busy = 1'b1;
            o_done = 1'b1;
         end
         default: ;
      endcase
   end

   // The captured chain output enters at the top, so after the last
   // shift the first-sampled bit has reached position 0.
   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               shreg_d = i_wdata;
               cnt_d   = '0;
            end
         end
         S_SHIFT: begin
            shreg_d = {i_scan_in, shreg_q[CHAIN_LEN-1:1]};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) rdata_d = shreg_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shreg_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_rdata = rdata_q;

`ifdef SCAN_VERIFY_EN
   logic [CHAIN_LEN-1:0] cur_q, cur_d;
   logic [CHAIN_LEN-1:0] prev_q, prev_d;
   logic                 vld_q, vld_d;

   // cur holds this pass's word until DONE retires it into prev.
   always_comb begin
      cur_d  = cur_q;
      prev_d = prev_q;
      vld_d  = vld_q;
      if (state_q == S_IDLE && i_start) cur_d = i_wdata;
      if (state_q == S_DONE) begin
         prev_d = cur_q;
         vld_d  = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cur_q  <= '0;
         prev_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         cur_q  <= cur_d;
         prev_q <= prev_d;
         vld_q  <= vld_d;
      end
   end

   assign o_verify_err = (state_q == S_DONE) && vld_q
                         && (rdata_q != prev_q);
`else
   assign o_verify_err = 1'b0;
`endif

endmodule

// File: doc/dpll_scan_master.md
# dpll_scan_master

Serial scan-chain controller that drives the DPLL configuration scan chain from the host side. It accepts a parallel CHAIN_LEN-bit configuration word and shifts it into the chain through the chain's scan-enable and scan-input pins. At the same time it captures the bits leaving the chain's scan output into a parallel readback word. It sits beside `tt_dpll` in the test harness and in the on-chip bring-up logic, wired to the chain's scan_en, scan_in and scan_out pins.

## Interface
- CHAIN_LEN, 32, number of flops in the target scan chain; must be ≥ 2.
- i_clk  input  1  clock; the same clock that clocks the scan chain flops.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_start  input  1  request one full shift pass; sampled only in IDLE.
- i_wdata  input  CHAIN_LEN  word to load; bit 0 is shifted out first.
- o_busy  output  1  high while a pass is in progress (SHIFT and DONE).
- o_done  output  1  single-cycle pulse when a pass completes.
- o_rdata  output  CHAIN_LEN  readback word; bit k is the chain output captured on shift k.
- o_verify_err  output  1  readback-mismatch flag, valid with o_done (see Configuration).
- o_scan_en  output  1  connects to the chain's scan enable.
- o_scan_out  output  1  connects to the chain's scan input.
- i_scan_in  input  1  connects to the chain's scan output.

## Operation
- States:
  - IDLE: waits for i_start.
  - SHIFT: runs for exactly CHAIN_LEN cycles.
  - DONE: lasts 1 cycle, then returns to IDLE.
- IDLE → SHIFT on a rising edge with i_start=1. At that edge, i_wdata is latched into the shift register and the bit counter is cleared.
- SHIFT:
  - o_scan_en=1 and o_scan_out = shreg[0].
  - On each edge, i_scan_in is shifted into shreg[CHAIN_LEN-1] and shreg shifts right by one.
  - The counter increments on each edge.
  - The counter has width $clog2(CHAIN_LEN+1).
- SHIFT → DONE on the edge where the counter reaches CHAIN_LEN-1.
  - At that point, shreg holds the captured word, so that o_rdata[k] = the value of i_scan_in sampled at shift edge k.
- DONE:
  - o_done=1 and o_scan_en=0.
  - o_rdata is updated from shreg at the DONE entry edge.
  - o_rdata holds its value until the next DONE.
- While the state is not SHIFT, o_scan_out=0 and o_scan_en=0.
- i_start is ignored in SHIFT and DONE. It is not queued.
- i_wdata changes after the start edge do not affect the current pass.
- After one pass, the chain flop nearest scan_out holds i_wdata[0], and the flop nearest scan_in holds i_wdata[CHAIN_LEN-1].

## Timing
- Reset values (asynchronous):
  - State = IDLE.
  - o_busy=0, o_done=0, o_scan_en=0, o_scan_out=0, o_verify_err=0.
  - o_rdata=0, shreg=0, counter=0, and the verify-valid flag is cleared.
- Start accepted at edge t:
  - o_busy and o_scan_en rise after edge t.
  - o_scan_out = i_wdata[0] during cycle t+1.
  - o_scan_en stays high for CHAIN_LEN cycles.
  - o_done is high in cycle t+CHAIN_LEN+1.
  - o_busy falls after edge t+CHAIN_LEN+1.
- Back-to-back passes: i_start held high gives a new pass every CHAIN_LEN+2 cycles.
- Reset mid-SHIFT:
  - o_scan_en drops immediately and the pass is aborted.
  - Chain contents are undefined; the host must rerun a full pass.
- i_scan_in is sampled on the same edge at which the chain shifts. There is no extra capture latency.

## Configuration
- SCAN_VERIFY_EN defined:
  - The block keeps a copy of the last word it wrote, plus a valid flag. The valid flag is set at each DONE and cleared by reset.
  - In DONE, o_verify_err=1 iff the valid flag was set before this pass and o_rdata ≠ the stored word.
  - The stored word is then updated with the word written in this pass.
  - o_verify_err is high only during the DONE cycle.
- SCAN_VERIFY_EN undefined:
  - o_verify_err is tied to 0.
  - There is no storage for the previous word.

## Test plan
- Reset, then i_start with i_wdata=32'hA5A5_0F0F and the chain model preloaded with 0:
  - o_scan_out sequence is 1,1,1,1,0,0,0,0,… (LSB first) over 32 cycles with o_scan_en=1.
  - o_done pulses at cycle 33.
  - o_rdata=0.
- Second pass with 32'h1234_5678:
  - o_rdata=32'hA5A5_0F0F.
  - With SCAN_VERIFY_EN, o_verify_err=0.
- Chain model corrupts bit 5 between passes:
  - Readback differs at bit 5.
  - With SCAN_VERIFY_EN, o_verify_err=1 for exactly one cycle.
  - Without SCAN_VERIFY_EN, o_verify_err stays 0.
- Pulse i_start again in mid-SHIFT and on the DONE cycle:
  - Both pulses are ignored and o_scan_en stays high for exactly 32 cycles.
  - i_start held high continuously gives o_done every 34 cycles.
- Assert i_rst_n=0 at shift 10:
  - All outputs are 0 immediately.
  - The next pass behaves as the first pass after reset (o_verify_err=0).
- CHAIN_LEN=2 with i_wdata=2'b10:
  - o_scan_out = 0 then 1.
  - o_done is high in the 3rd cycle after the start edge.
